// File: rtl/scytale_codec.sv
// Scytale encrypt/decrypt codec: collects a message, then on START_TOKEN streams it
// back permuted through a ready/valid output, padding unwritten grid cells.
module scytale_codec #(
    parameter int                   D_WIDTH       = 8,
    parameter int                   KEY_WIDTH     = 8,
    parameter int                   MAX_NOF_CHARS = 50,
    parameter logic [D_WIDTH-1:0]   START_TOKEN   = 8'hFA,
    parameter logic [D_WIDTH-1:0]   PAD_CHAR      = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [D_WIDTH-1:0]   data_i,
    input  logic                 valid_i,
    input  logic                 mode_i,
    input  logic [KEY_WIDTH-1:0] key_N,
    input  logic [KEY_WIDTH-1:0] key_M,
    output logic [D_WIDTH-1:0]   data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 busy,
    output logic                 err_o
);
    localparam int CW = $clog2(MAX_NOF_CHARS + 1);
    localparam int LW = 2 * KEY_WIDTH;
    localparam int AW = (MAX_NOF_CHARS > 1) ? $clog2(MAX_NOF_CHARS) : 1;

    typedef enum logic {S_COLLECT, S_EMIT} state_t;

    state_t               r_state, w_state_nxt;
    logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic [D_WIDTH-1:0]   r_data_o;
    logic                 r_valid_o;
    logic                 r_busy;
    logic                 r_err;
    logic [LW-1:0]        r_len;
    logic [LW-1:0]        r_beat;
    logic [LW-1:0]        r_idx;
    logic [LW-1:0]        r_j;
    logic [KEY_WIDTH-1:0] r_k;
    logic [KEY_WIDTH-1:0] r_stride;
    logic [KEY_WIDTH-1:0] r_inner;

    logic                 w_char, w_token, w_reject, w_xfer, w_last, w_wrap;
    logic [LW-1:0]        w_len, w_next_idx, w_next_j;
    logic [KEY_WIDTH-1:0] w_next_k;
    logic [D_WIDTH-1:0]   w_next_char;

    assign w_char  = (r_state == S_COLLECT) && valid_i && (data_i != START_TOKEN);
    assign w_token = (r_state == S_COLLECT) && valid_i && (data_i == START_TOKEN);
    assign w_len   = LW'(key_N) * LW'(key_M);

    assign w_reject = (key_N == '0) || (key_M == '0) || (r_count == '0) || r_ovf ||
                      (LW'(r_count) > w_len) || (w_len > LW'(MAX_NOF_CHARS));

    assign w_xfer = r_valid_o && ready_i;
    assign w_last = w_xfer && ((r_beat + LW'(1)) == r_len);

    // Index walks by stride within a column; on wrap it restarts at the next column.
    assign w_wrap      = (r_k == (r_inner - 1'b1));
    assign w_next_idx  = w_wrap ? (r_j + LW'(1)) : (r_idx + LW'(r_stride));
    assign w_next_j    = w_wrap ? (r_j + LW'(1)) : r_j;
    assign w_next_k    = w_wrap ? '0 : (r_k + 1'b1);
    assign w_next_char = (w_next_idx < LW'(r_count)) ? r_buf[w_next_idx[AW-1:0]] : PAD_CHAR;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= S_COLLECT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_token && !w_reject) w_state_nxt = S_EMIT;
            S_EMIT:    if (w_last)               w_state_nxt = S_COLLECT;
            default:                             w_state_nxt = S_COLLECT;
        endcase
    end

    // Storage is never cleared; r_count alone marks which entries are live.
    always_ff @(posedge clk) begin
        if (w_char && (r_count < CW'(MAX_NOF_CHARS)))
            r_buf[r_count[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_data_o  <= '0;
            r_valid_o <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_len     <= '0;
            r_beat    <= '0;
            r_idx     <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_stride  <= '0;
            r_inner   <= '0;
        end else begin
            r_err <= 1'b0;
            if (w_char) begin
                if (r_count < CW'(MAX_NOF_CHARS)) r_count <= r_count + 1'b1;
                else                              r_ovf   <= 1'b1;
            end
            if (w_token) begin
                r_ovf <= 1'b0;
                if (w_reject) begin
                    r_err   <= 1'b1;
                    r_count <= '0;
                end else begin
                    r_busy    <= 1'b1;
                    r_valid_o <= 1'b1;
                    r_data_o  <= r_buf[0];
                    r_len     <= w_len;
                    r_beat    <= '0;
                    r_idx     <= '0;
                    r_j       <= '0;
                    r_k       <= '0;
                    r_stride  <= mode_i ? key_M : key_N;
                    r_inner   <= mode_i ? key_N : key_M;
                end
            end
            if (w_xfer) begin
                if (w_last) begin
                    r_valid_o <= 1'b0;
                    r_data_o  <= '0;
                    r_busy    <= 1'b0;
                    r_count   <= '0;
                end else begin
                    r_data_o <= w_next_char;
                    r_beat   <= r_beat + LW'(1);
                    r_idx    <= w_next_idx;
                    r_j      <= w_next_j;
                    r_k      <= w_next_k;
                end
            end
        end
    end

    assign data_o  = r_data_o;
    assign valid_o = r_valid_o;
    assign busy    = r_busy;
    assign err_o   = r_err;
endmodule

// File: tb/tb_scytale_codec.sv
// Bench for scytale_codec: directed and randomized messages checked against a
// position-based scytale model, with backpressure, error and reset scenarios.
module tb_scytale_codec;
    localparam int         W    = 8;
    localparam int         MAXC = 50;
    localparam logic [7:0] TOK  = 8'hFA;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] data_i;
    logic         valid_i;
    logic         mode_i;
    logic [7:0]   key_N;
    logic [7:0]   key_M;
    logic [W-1:0] data_o;
    logic         valid_o;
    logic         ready_i;
    logic         busy;
    logic         err_o;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msg_q[$];

    scytale_codec dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .mode_i(mode_i), .key_N(key_N), .key_M(key_M), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i), .busy(busy), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_msg(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    task automatic rand_msg(input int cnt);
        msg_q.delete();
        for (int i = 0; i < cnt; i++) msg_q.push_back(W'($urandom_range(0, 249)));
    endtask

    // Output position p of an N x M scytale: decrypt reads column-major, encrypt row-major.
    task automatic model(input bit mode, input int n, input int m);
        int idx;
        exp_q.delete();
        for (int p = 0; p < n * m; p++) begin
            idx = mode ? (p % n) * m + p / n : (p % m) * n + p / m;
            exp_q.push_back(idx < msg_q.size() ? msg_q[idx] : 8'h00);
        end
    endtask

    task automatic send_msg(input bit mode, input int n, input int m);
        foreach (msg_q[i]) begin
            valid_i = 1'b1;
            data_i  = msg_q[i];
            step();
        end
        valid_i = 1'b1;
        data_i  = TOK;
        mode_i  = mode;
        key_N   = n[7:0];
        key_M   = m[7:0];
        step();
        valid_i = 1'b0;
        data_i  = '0;
        mode_i  = 1'($urandom);
        key_N   = 8'($urandom);
        key_M   = 8'($urandom);
    endtask

    task automatic run_msg(input string name, input bit mode, input int n, input int m,
                           input int stall_after, input bit rand_bp, input bit inject_tok);
        int got = 0;
        int cyc = 0;
        int stalls = 0;
        model(mode, n, m);
        send_msg(mode, n, m);
        while (got < exp_q.size() && cyc < 2000) begin
            ready_i = 1'b1;
            if (stall_after >= 0 && got == stall_after && stalls < 3) begin
                ready_i = 1'b0;
                stalls++;
            end else if (rand_bp && $urandom_range(0, 3) == 0) begin
                ready_i = 1'b0;
            end
            if (inject_tok && got == 1) begin
                valid_i = 1'b1; data_i = TOK; mode_i = ~mode; key_N = 8'd0;
            end else begin
                valid_i = 1'b0;
            end
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_q[got] || busy !== 1'b1 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL %s beat %0d: valid_o=%b data_o=%h busy=%b err_o=%b, required valid_o=1 data_o=%h busy=1 err_o=0",
                         name, got, valid_o, data_o, busy, err_o, exp_q[got]);
            end
            if (ready_i) got++;
            step();
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        if (got < exp_q.size()) begin
            errors++;
            $display("FAIL %s timeout: got %0d beats, required %0d", name, got, exp_q.size());
        end
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s end: valid_o=%b data_o=%h busy=%b, required 0 00 0", name, valid_o, data_o, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; valid_i = 1'b0; data_i = '0; mode_i = 1'b0;
        key_N = '0; key_M = '0; ready_i = 1'b1;
        #2;
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || busy !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid_o=%b data_o=%h busy=%b err_o=%b, required all 0", valid_o, data_o, busy, err_o);
        end
        step();
        rst_n = 1'b0;
        step();
    endtask

    task automatic test_decrypt();
        set_msg("ADBECF");
        run_msg("decrypt", 1'b0, 2, 3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_encrypt_roundtrip();
        set_msg("ABCDEF");
        run_msg("encrypt", 1'b1, 2, 3, -1, 1'b0, 1'b0);
        set_msg("ADBECF");
        run_msg("encrypt_back", 1'b0, 2, 3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_padding();
        set_msg("ADBEC");
        run_msg("padding", 1'b0, 2, 3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        set_msg("ADBECF");
        run_msg("backpressure", 1'b0, 2, 3, 2, 1'b0, 1'b0);
    endtask

    task automatic check_err(input string name, input int n, input int m);
        send_msg(1'b0, n, m);
        checks++;
        if (err_o !== 1'b1 || valid_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse: err_o=%b valid_o=%b busy=%b, required 1 0 0", name, err_o, valid_o, busy);
        end
        step();
        checks++;
        if (err_o !== 1'b0 || valid_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after: err_o=%b valid_o=%b busy=%b, required 0 0 0", name, err_o, valid_o, busy);
        end
        set_msg("ADBECF");
        run_msg({name, "_recover"}, 1'b0, 2, 3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        set_msg("ABC");
        check_err("err_keyn0", 0, 3);
        set_msg("ABC");
        check_err("err_keym0", 2, 0);
        msg_q.delete();
        check_err("err_empty", 2, 3);
        set_msg("ABCDEFG");
        check_err("err_toolong", 2, 3);
        rand_msg(52);
        check_err("err_overflow", 5, 10);
        set_msg("ABCDEFGHIJ");
        check_err("err_keybig", 8, 8);
    endtask

    task automatic test_reset_mid();
        set_msg("ADBECF");
        model(1'b0, 2, 3);
        send_msg(1'b0, 2, 3);
        ready_i = 1'b1;
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (valid_o !== 1'b1 || data_o !== exp_q[b]) begin
                errors++;
                $display("FAIL reset_mid beat %0d: valid_o=%b data_o=%h, required 1 %h", b, valid_o, data_o, exp_q[b]);
            end
            step();
        end
        rst_n = 1'b1;
        #2;
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: valid_o=%b data_o=%h busy=%b, required 0 00 0", valid_o, data_o, busy);
        end
        step();
        rst_n = 1'b0;
        step();
        set_msg("ABCDEF");
        run_msg("reset_fresh", 1'b1, 2, 3, -1, 1'b0, 1'b0);
    endtask

    task automatic test_token_in_emit();
        set_msg("ADBECF");
        run_msg("token_in_emit", 1'b0, 2, 3, -1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        int n, m, cnt;
        bit mode;
        for (int it = 0; it < 10; it++) begin
            n    = $urandom_range(1, 7);
            m    = $urandom_range(1, 7);
            cnt  = $urandom_range(1, n * m);
            mode = 1'($urandom);
            rand_msg(cnt);
            run_msg($sformatf("random%0d", it), mode, n, m, -1, 1'b1, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_decrypt();
        test_encrypt_roundtrip();
        test_padding();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_token_in_emit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
